// File: rtl/padder_stream.sv
// Keccak pad10*1 message padder: shifts host words into a rate-sized block,
// appends 0x01 after the last byte and 0x80 in the block's top byte, then holds the block until acked.
module padder_stream #(
  parameter  int WORD_BYTES = 8,
  parameter  int RATE_WORDS = 9,
  localparam int W          = 8 * WORD_BYTES,
  localparam int B          = W * RATE_WORDS,
  localparam int BNW        = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1,
  localparam int CW         = $clog2(RATE_WORDS + 1)
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [W-1:0]   i_in,
  input  logic           i_in_ready,
  input  logic           i_is_last,
  input  logic [BNW-1:0] i_byte_num,
  output logic           o_busy,
  output logic [B-1:0]   o_out,
  output logic           o_buffer_full,
  output logic           o_last_block,
  input  logic           i_f_ack
);

  typedef enum logic [1:0] {ACCEPT, PAD, FULL} state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [B-1:0]    r_out, w_out_n;
  logic            r_last, w_last_n;

  logic            w_accept;
  logic            w_final_slot;
  logic [W-1:0]    w_lastw;
  logic [W-1:0]    w_word;
  logic [B+W-1:0]  w_shift;

  assign o_busy        = (r_state == FULL) || (r_state == PAD);
  assign o_buffer_full = (r_state == FULL);
  assign o_last_block  = r_last;
  assign o_out         = r_out;

  assign w_accept     = i_in_ready && !o_busy;
  assign w_final_slot = (r_cnt == CW'(RATE_WORDS - 1));

  // Last word: keep bytes below byte_num, 0x01 at byte_num, zeros above.
  always_comb begin
    w_lastw = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (b < int'(i_byte_num))
        w_lastw[8*b +: 8] = i_in[8*b +: 8];
      else if (b == int'(i_byte_num))
        w_lastw[8*b +: 8] = 8'h01;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_out_n   = r_out;
    w_last_n  = r_last;
    w_word    = '0;
    w_shift   = '0;
    case (r_state)
      ACCEPT: begin
        if (w_accept) begin
          if (i_is_last) begin
            w_word = w_lastw;
            if (w_final_slot) w_word[W-1 -: 8] = w_word[W-1 -: 8] | 8'h80;
          end else begin
            w_word = i_in;
          end
          w_shift = {r_out, w_word};
          w_out_n = w_shift[B-1:0];
          w_cnt_n = r_cnt + CW'(1);
          if (i_is_last) begin
            if (w_final_slot) begin
              w_state_n = FULL;
              w_last_n  = 1'b1;
            end else begin
              w_state_n = PAD;
            end
          end else if (w_final_slot) begin
            w_state_n = FULL;
            w_last_n  = 1'b0;
          end
        end
      end
      PAD: begin
        if (w_final_slot) w_word = {8'h80, {(W-8){1'b0}}};
        w_shift = {r_out, w_word};
        w_out_n = w_shift[B-1:0];
        w_cnt_n = r_cnt + CW'(1);
        if (w_final_slot) begin
          w_state_n = FULL;
          w_last_n  = 1'b1;
        end
      end
      FULL: begin
        // out is kept; the next message simply shifts over it.
        if (i_f_ack) begin
          w_state_n = ACCEPT;
          w_cnt_n   = '0;
          w_last_n  = 1'b0;
        end
      end
      default: w_state_n = ACCEPT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ACCEPT;
      r_cnt   <= '0;
      r_out   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_out   <= w_out_n;
      r_last  <= w_last_n;
    end
  end

endmodule

// File: tb/tb_padder_stream.sv
// Directed bench for padder_stream with WORD_BYTES=8, RATE_WORDS=9.
module tb_padder_stream;

  localparam int W = 64;
  localparam int B = 576;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  din = '0;
  logic          rdy = 1'b0;
  logic          lst = 1'b0;
  logic [2:0]    bn = '0;
  logic          fack = 1'b0;
  logic          busy, full, lastb;
  logic [B-1:0]  dout;

  int checks = 0;
  int failures = 0;

  padder_stream #(.WORD_BYTES(8), .RATE_WORDS(9)) dut (
    .i_clk(clk), .i_reset(rst), .i_in(din), .i_in_ready(rdy), .i_is_last(lst),
    .i_byte_num(bn), .o_busy(busy), .o_out(dout), .o_buffer_full(full),
    .o_last_block(lastb), .i_f_ack(fack)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] wd(input int i);
    return dout[B-1-64*i -: 64];
  endfunction

  task automatic send(input logic [63:0] w, input logic l, input logic [2:0] b);
    @(negedge clk);
    din = w; rdy = 1'b1; lst = l; bn = b;
    @(posedge clk); #1;
    rdy = 1'b0; lst = 1'b0;
  endtask

  task automatic wait_full(output int n);
    n = 0;
    while (!full && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic ack;
    @(negedge clk);
    fack = 1'b1;
    @(posedge clk); #1;
    fack = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (dout !== '0 || full !== 1'b0 || lastb !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: out_nz=%0b full=%b last=%b busy=%b want 0 0 0 0", |dout, full, lastb, busy);
    end
    @(negedge clk); rst = 1'b0;
    send(64'h1111, 0, 0);
    send(64'h2222, 1, 2);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dout !== '0 || full !== 1'b0 || lastb !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: out_nz=%0b full=%b last=%b busy=%b want 0 0 0 0", |dout, full, lastb, busy);
    end
    @(negedge clk); rst = 1'b0;
    send(64'hDEAD, 0, 0);
    checks++;
    if (dout !== {{(B-64){1'b0}}, 64'hDEAD} || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_slot0: low=%h busy=%b want low=dead others 0 busy 0", dout[63:0], busy);
    end
    do_reset();
  endtask

  task automatic test_short;
    logic [63:0] exp0 [8];
    int n;
    exp0 = '{64'h1, 64'h1ef, 64'h1cdef, 64'h1abcdef, 64'h190abcdef,
             64'h17890abcdef, 64'h1567890abcdef, 64'h134567890abcdef};
    for (int b = 0; b < 8; b++) begin
      send(64'h1234567890ABCDEF, 1, 3'(b));
      checks++;
      if (busy !== 1'b1 || full !== 1'b0) begin
        failures++;
        $display("FAIL short_busy bn=%0d: busy=%b full=%b want 1 0", b, busy, full);
      end
      wait_full(n);
      checks++;
      if (n != 8 || lastb !== 1'b1) begin
        failures++;
        $display("FAIL short_latency bn=%0d: edges=%0d last=%b want 8 1", b, n, lastb);
      end
      checks++;
      if (wd(0) !== exp0[b] || dout[511:64] !== '0 || wd(8) !== 64'h8000000000000000) begin
        failures++;
        $display("FAIL short_block bn=%0d: w0=%h w8=%h mid_nz=%b want %h 8000000000000000 0",
                 b, wd(0), wd(8), |dout[511:64], exp0[b]);
      end
      ack();
      checks++;
      if (full !== 1'b0 || lastb !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL short_ack bn=%0d: full=%b last=%b busy=%b want 0 0 0", b, full, lastb, busy);
      end
    end
  endtask

  task automatic test_final_merge;
    for (int i = 0; i < 8; i++) send(64'h0101010101010100 + 64'(i), 0, 0);
    checks++;
    if (full !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL merge_early: full=%b busy=%b want 0 0", full, busy);
    end
    send(64'h1234567890ABCDEF, 1, 7);
    checks++;
    if (full !== 1'b1 || lastb !== 1'b1 || wd(8) !== 64'h8134567890ABCDEF ||
        wd(0) !== 64'h0101010101010100 || wd(7) !== 64'h0101010101010107) begin
      failures++;
      $display("FAIL merge_block: full=%b last=%b w0=%h w7=%h w8=%h want 1 1 0101010101010100 0101010101010107 8134567890abcdef",
               full, lastb, wd(0), wd(7), wd(8));
    end
    ack();
  endtask

  task automatic test_two_block;
    int n;
    for (int i = 0; i < 9; i++) send(64'hC0DE000000000000 + 64'(i), 0, 0);
    checks++;
    if (full !== 1'b1 || lastb !== 1'b0 || wd(0) !== 64'hC0DE000000000000 || wd(8) !== 64'hC0DE000000000008) begin
      failures++;
      $display("FAIL two_first: full=%b last=%b w0=%h w8=%h want 1 0 c0de000000000000 c0de000000000008",
               full, lastb, wd(0), wd(8));
    end
    ack();
    send(64'hFFFFFFFFFFFFFFFF, 1, 0);
    wait_full(n);
    checks++;
    if (n != 8 || lastb !== 1'b1 || wd(0) !== 64'h1 || dout[511:64] !== '0 || wd(8) !== 64'h8000000000000000) begin
      failures++;
      $display("FAIL two_second: edges=%0d last=%b w0=%h w8=%h want 8 1 1 8000000000000000", n, lastb, wd(0), wd(8));
    end
    ack();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) send(64'hB000000000000000 + 64'(i), 0, 0);
    @(negedge clk);
    rdy = 1'b1; din = 64'hB000000000000008;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); din = 64'hEEEE000000000000 + 64'(i);
      @(posedge clk); #1;
    end
    checks++;
    if (full !== 1'b1 || busy !== 1'b1 || wd(8) !== 64'hB000000000000008 || wd(0) !== 64'hB000000000000000) begin
      failures++;
      $display("FAIL bp_hold: full=%b busy=%b w0=%h w8=%h want 1 1 b000000000000000 b000000000000008",
               full, busy, wd(0), wd(8));
    end
    @(negedge clk);
    fack = 1'b1; din = 64'h5A5A5A5A5A5A5A5A;
    @(posedge clk); #1;
    fack = 1'b0;
    checks++;
    if (full !== 1'b0 || busy !== 1'b0 || wd(8) !== 64'hB000000000000008) begin
      failures++;
      $display("FAIL bp_ack_edge: full=%b busy=%b w8=%h want 0 0 b000000000000008", full, busy, wd(8));
    end
    @(posedge clk); #1;
    rdy = 1'b0;
    checks++;
    if (wd(8) !== 64'h5A5A5A5A5A5A5A5A || wd(7) !== 64'hB000000000000008) begin
      failures++;
      $display("FAIL bp_next_accept: w7=%h w8=%h want b000000000000008 5a5a5a5a5a5a5a5a", wd(7), wd(8));
    end
    @(negedge clk); fack = 1'b1;
    @(posedge clk); #1; fack = 1'b0;
    checks++;
    if (full !== 1'b0 || busy !== 1'b0 || wd(8) !== 64'h5A5A5A5A5A5A5A5A) begin
      failures++;
      $display("FAIL bp_stray_ack: full=%b busy=%b w8=%h want 0 0 5a5a5a5a5a5a5a5a", full, busy, wd(8));
    end
    for (int i = 0; i < 7; i++) send(64'h7000000000000000 + 64'(i), 0, 0);
    checks++;
    if (full !== 1'b0) begin
      failures++;
      $display("FAIL bp_count_early: full=%b want 0 after 8 words", full);
    end
    send(64'h7000000000000007, 0, 0);
    checks++;
    if (full !== 1'b1 || lastb !== 1'b0 || wd(0) !== 64'h5A5A5A5A5A5A5A5A || wd(8) !== 64'h7000000000000007) begin
      failures++;
      $display("FAIL bp_count_full: full=%b last=%b w0=%h w8=%h want 1 0 5a5a5a5a5a5a5a5a 7000000000000007",
               full, lastb, wd(0), wd(8));
    end
    ack();
  endtask

  task automatic test_reset_mid_pad;
    int n;
    send(64'h0123456789ABCDEF, 1, 2);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dout !== '0 || full !== 1'b0 || lastb !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pad_reset: out_nz=%0b full=%b last=%b busy=%b want 0 0 0 0", |dout, full, lastb, busy);
    end
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (full !== 1'b0 || busy !== 1'b0 || dout !== '0) begin
      failures++;
      $display("FAIL pad_reset_idle: full=%b busy=%b out_nz=%b want 0 0 0", full, busy, |dout);
    end
    send(64'h000000000000AABB, 1, 1);
    wait_full(n);
    checks++;
    if (n != 8 || lastb !== 1'b1 || wd(0) !== 64'h1BB || dout[511:64] !== '0 || wd(8) !== 64'h8000000000000000) begin
      failures++;
      $display("FAIL pad_reset_new: edges=%0d last=%b w0=%h w8=%h want 8 1 1bb 8000000000000000", n, lastb, wd(0), wd(8));
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_short();
    test_final_merge();
    test_two_block();
    test_back_to_back();
    test_reset_mid_pad();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/padder_stream.md
# padder_stream

Parametrised, sequential Keccak-style message padder that accepts the message one word per cycle and assembles rate-sized blocks for the permutation core. It applies pad10*1 padding: a 0x01 byte after the last message byte, zero words to the end of the block, and 0x80 ORed into the top byte of the block's final word. It generalises the single-word combinational padder to a configurable word width and rate, with block buffering and backpressure. It sits between the host input interface and the f-permutation.

## Interface
- WORD_BYTES, 8, bytes per input word; W = 8*WORD_BYTES.
- RATE_WORDS, 9, words per output block; block width B = W*RATE_WORDS.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in  in  W  message word; valid bytes occupy the low bytes.
- in_ready  in  1  `in` is valid this cycle.
- is_last  in  1  qualifies `in` as the final (partial) word of the message.
- byte_num  in  clog2(WORD_BYTES)  valid bytes in the last word, 0..WORD_BYTES-1; ignored unless is_last.
- busy  out  1  input words are not accepted this cycle.
- out  out  B  assembled block; the first word of the block is at out[B-1 -: W], the last at out[W-1:0].
- buffer_full  out  1  `out` holds a complete block.
- last_block  out  1  qualifies buffer_full: this block contains the padding.
- f_ack  in  1  consumer has taken `out`; effective only while buffer_full=1.

## Operation
- **Word acceptance.** A word is accepted when in_ready=1 and busy=0.
  - busy = buffer_full OR (state==PAD).
  - The accepted word shifts into the block: out <= {out[B-W-1:0], word}.
  - The word counter cnt (0..RATE_WORDS) increments on each accept.
- **States:** ACCEPT, PAD, FULL.
- **ACCEPT, non-last word.** The word is shifted in unchanged.
  - If cnt reaches RATE_WORDS, go to FULL with last_block=0.
- **ACCEPT, last word (is_last=1).** The shifted word is (in AND low-byte mask of byte_num bytes) OR (8'h01 << 8*byte_num).
  - Bytes at and above byte_num are replaced.
  - If the word lands in slot RATE_WORDS-1, 8'h80 is additionally ORed into its top byte; go to FULL with last_block=1.
  - Otherwise go to PAD.
- **PAD.** Each cycle shifts in one zero word and increments cnt. When filling the final slot, the shifted word is {8'h80, zeros}. Then go to FULL with last_block=1.
- **FULL.** buffer_full=1; out and last_block are stable.
  - On f_ack: cnt clears to 0, buffer_full clears, last_block clears, and the state returns to ACCEPT.
  - out is not cleared on ack; it is overwritten by subsequent shifts.
- After a last_block is acked, the next accepted word starts a new message.
- Only one 0x01 and one 0x80 marker are ever inserted per message. A last word with byte_num=WORD_BYTES-1 in the final slot yields a top byte of 8'h81.
- in_ready/is_last during busy are ignored; no word is lost as long as the host holds it until busy=0.
- f_ack while buffer_full=0 has no effect.

## Timing
- **Reset values:** out=0, buffer_full=0, last_block=0, busy=0, cnt=0, state=ACCEPT. Reset mid-block or mid-PAD discards everything.
- **Accept latency:** a word accepted at edge t is visible in out after t.
- **Non-padded block:** buffer_full rises after the edge accepting word RATE_WORDS-1.
- **Padded block:** for a last word in slot k, buffer_full rises RATE_WORDS-1-k edges after the accepting edge (0 when k=RATE_WORDS-1).
- **Ack:** f_ack sampled high at edge t with buffer_full=1 clears buffer_full after t. busy drops after t, so an in_ready in the same cycle as f_ack is not accepted. The earliest next accept is edge t+1.
- **Throughput:** one word per cycle in ACCEPT; one zero word per cycle in PAD.

## Test plan
Parameters for all scenarios: WORD_BYTES=8, RATE_WORDS=9.

- **Reset.** Assert reset asynchronously mid-cycle -> out=0, buffer_full=0, last_block=0, busy=0 immediately. Release; a following accept goes to slot 0.
- **Single short message.** One word in=64'h1234567890ABCDEF, is_last=1, byte_num=3 -> busy high for 8 cycles.
  - buffer_full rises 8 edges after the accept, with last_block=1.
  - Word0 = 64'h0000000001ABCDEF; words1..7 = 0; word8 = 64'h8000000000000000.
  - Repeat for byte_num=0..7: word0 = 1, 1ef, 1cdef, 1abcdef, 190abcdef, 17890abcdef, 1567890abcdef, 134567890abcdef.
- **Final-slot merge.** 8 full words, then in=64'h1234567890ABCDEF, is_last=1, byte_num=7 -> buffer_full after that same edge, last_block=1, word8 = 64'h8134567890ABCDEF.
- **Two-block message.** 9 full words -> buffer_full=1, last_block=0. After f_ack, one word with is_last=1, byte_num=0 -> second block: word0=64'h1, word8=64'h8000000000000000, last_block=1.
- **Backpressure.**
  - Hold in_ready=1 with distinct words across buffer_full -> no word is accepted while busy.
  - f_ack and in_ready in the same cycle -> the word is accepted on the next edge into slot 0; no duplicate or drop.
  - Stray f_ack while buffer_full=0 -> no effect.
- **Reset mid-PAD.** Assert reset 3 cycles into PAD -> all cleared, no buffer_full. A new message then pads correctly from slot 0.
